fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 The module SHALL have parameter NOP_INSTR, default 32'h0000_0000 (sll $0,$0,0), the instruction inserted on flush and reset.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port stallF  input  1  hold PC (hazard unit).
REQ-006 Port stallD  input  1  hold IF/ID register (hazard unit).
REQ-007 Port flushD  input  1  clear IF/ID register to NOP.
REQ-008 Port pcSrcD  input  1  branch taken in decode; redirect PC.
REQ-009 Port pcBranchD  input  32  branch target byte address.
REQ-010 Port imemAddr  output  32  instruction memory byte address (current PC).
REQ-011 Port imemRdata  input  32  instruction word, combinational read of imemAddr.
REQ-012 Port instrD  output  32  registered instruction presented to the control unit.
REQ-013 Port pcPlus4D  output  32  registered PC+4 of instrD.
REQ-014 Port validD  output  1  instrD holds a fetched (non-bubble) instruction.
REQ-015 Port alignErr  output  1  sticky flag: misaligned branch target seen.

Function
REQ-016 imemAddr SHALL equal the PC register combinationally; zero cycles from PC change to address.
REQ-017 PC next-value priority SHALL be: reset > stallF (hold) > pcSrcD with aligned target (load pcBranchD) > PC+4.
REQ-018 PC+4 SHALL be computed modulo 2^32; 32'hFFFF_FFFC advances to 32'h0000_0000 without error.
REQ-019 A redirect with pcBranchD[1:0] != 2'b00 SHALL be ignored (PC advances to PC+4) and SHALL set alignErr on the same edge.
REQ-020 alignErr SHALL remain 1 until reset; no other event clears it.
REQ-021 IF/ID next-value priority SHALL be: reset > flushD > stallD (hold) > load {imemRdata, PC+4, 1}.
REQ-022 flushD SHALL load instrD=NOP_INSTR, pcPlus4D=32'h0, validD=0, also when stallD=1.
REQ-023 stallF and stallD SHALL act independently; stallF=0 with stallD=1 drops the fetched word, and the bench treats that as legal hazard-unit behaviour.
REQ-024 Fetch-to-decode latency SHALL be one cycle: word at imemAddr in cycle n appears on instrD in cycle n+1.
REQ-025 pcSrcD=1 with stallF=0 SHALL NOT flush IF/ID by itself; the wrong-path slot is removed only by flushD from the hazard unit.
REQ-026 All outputs except imemAddr SHALL be driven directly from registers.

Reset
REQ-027 On a rising edge with rst_n=0 the module SHALL set PC=RESET_PC, instrD=NOP_INSTR, pcPlus4D=32'h0, validD=0, alignErr=0.
REQ-028 Reset SHALL override stallF, stallD, flushD and pcSrcD on the same edge.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL discard the pending operation; the first fetch after release SHALL be from RESET_PC.
REQ-030 The first edge with rst_n=1 SHALL load IF/ID from RESET_PC and set PC=RESET_PC+4.

Verification
REQ-031 Sequential fetch: imem[0]=32'h0043_0820, imem[4]=32'h8C22_0004, no stalls -> after edges 1 and 2 after release, instrD=32'h0043_0820 then 32'h8C22_0004, pcPlus4D=4 then 8, validD=1.
REQ-032 Stall: stallF=stallD=1 for 2 cycles with PC=8 -> imemAddr stays 8, instrD and pcPlus4D unchanged; after release, fetching resumes at 8.
REQ-033 Branch plus flush: pcSrcD=1, pcBranchD=32'h40, flushD=1 on one edge -> PC=32'h40, instrD=32'h0, validD=0; next edge instrD=imem[32'h40], pcPlus4D=32'h44.
REQ-034 Misaligned branch: pcSrcD=1, pcBranchD=32'h42, PC=32'h10 -> PC=32'h14, alignErr=1, alignErr still 1 after 5 further cycles.
REQ-035 Wrap: RESET_PC=32'hFFFF_FFFC -> first edge after release: pcPlus4D=32'h0, PC=32'h0, alignErr=0.
REQ-036 Reset mid-operation: rst_n=0 on the same edge as stallD=1, flushD=1, pcSrcD=1 -> PC=RESET_PC, instrD=NOP_INSTR, validD=0, alignErr=0.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard-unit controls, decode redirect, imem port and IF/ID outputs.
// The slave modport is the fetch stage; the master modport is whatever surrounds it.
interface fetch_stage_if;
  logic        stallF;
  logic        stallD;
  logic        flushD;
  logic        pcSrcD;
  logic [31:0] pcBranchD;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata;
  logic [31:0] instrD;
  logic [31:0] pcPlus4D;
  logic        validD;
  logic        alignErr;

  modport slave (
    input  stallF, stallD, flushD, pcSrcD, pcBranchD, imemRdata,
    output imemAddr, instrD, pcPlus4D, validD, alignErr
  );

  modport master (
    output stallF, stallD, flushD, pcSrcD, pcBranchD, imemRdata,
    input  imemAddr, instrD, pcPlus4D, validD, alignErr
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register with stall/redirect, IF/ID pipeline register,
// and a sticky flag for misaligned branch targets.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.slave  fs
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;
  logic        align_err_q, align_err_d;
  logic        target_aligned;
  logic        redirect_ok;
  logic        redirect_bad;

  assign pc_plus4       = pc_q + 32'd4;
  assign target_aligned = (fs.pcBranchD[1:0] == 2'b00);
  assign redirect_ok    = fs.pcSrcD && target_aligned;
  assign redirect_bad   = fs.pcSrcD && !target_aligned;

  // A redirect only takes effect when the PC is free to move, so a misaligned
  // target is flagged only on edges where the redirect would have been taken.
  always_comb begin
    pc_d        = pc_q;
    align_err_d = align_err_q;
    if (!fs.stallF) begin
      pc_d = redirect_ok ? fs.pcBranchD : pc_plus4;
      if (redirect_bad) begin
        align_err_d = 1'b1;
      end
    end
  end

  always_comb begin
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (fs.flushD) begin
      instr_d   = NOP_INSTR;
      pcplus4_d = 32'h0;
      valid_d   = 1'b0;
    end else if (!fs.stallD) begin
      instr_d   = fs.imemRdata;
      pcplus4_d = pc_plus4;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      pcplus4_q   <= 32'h0;
      valid_q     <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pcplus4_q   <= pcplus4_d;
      valid_q     <= valid_d;
      align_err_q <= align_err_d;
    end
  end

  assign fs.imemAddr = pc_q;
  assign fs.instrD   = instr_q;
  assign fs.pcPlus4D = pcplus4_q;
  assign fs.validD   = valid_q;
  assign fs.alignErr = align_err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, a wrap-around instance, and a
// randomized run checked against a rule-level reference model.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst_n;
  logic w_rst_n;

  always #5 clk = ~clk;

  fetch_stage_if fs_if ();
  fetch_stage_if w_if ();

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0043_0820;
      32'h0000_0004: return 32'h8C22_0004;
      default:       return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  assign fs_if.imemRdata = imem_word(fs_if.imemAddr);
  assign w_if.imemRdata  = imem_word(w_if.imemAddr);

  fetch_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fs    (fs_if)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) dut_wrap (
    .clk   (clk),
    .rst_n (w_rst_n),
    .fs    (w_if)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        stallF;
    logic        stallD;
    logic        flushD;
    logic        pcSrcD;
    logic [31:0] br;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pp4;
    logic        e_valid;
    logic        e_aerr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic sf, input logic sd, input logic fl,
                              input logic ps, input logic [31:0] br, input logic [31:0] pc,
                              input logic [31:0] ins, input logic [31:0] pp4,
                              input logic v, input logic ae);
    vec_t t;
    t.rst_n = r; t.stallF = sf; t.stallD = sd; t.flushD = fl; t.pcSrcD = ps; t.br = br;
    t.e_pc = pc; t.e_instr = ins; t.e_pp4 = pp4; t.e_valid = v; t.e_aerr = ae;
    return t;
  endfunction

  task automatic drive(input logic r, input logic sf, input logic sd, input logic fl,
                       input logic ps, input logic [31:0] br);
    rst_n           = r;
    fs_if.stallF    = sf;
    fs_if.stallD    = sd;
    fs_if.flushD    = fl;
    fs_if.pcSrcD    = ps;
    fs_if.pcBranchD = br;
  endtask

  task automatic check_all(input int idx, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] pp4, input logic v, input logic ae);
    chk("imemAddr", idx, fs_if.imemAddr, pc);
    chk("instrD",   idx, fs_if.instrD,   ins);
    chk("pcPlus4D", idx, fs_if.pcPlus4D, pp4);
    chk("validD",   idx, {31'b0, fs_if.validD},   {31'b0, v});
    chk("alignErr", idx, {31'b0, fs_if.alignErr}, {31'b0, ae});
  endtask

  vec_t tbl[21];

  // reference model state
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_valid, m_aerr;

  initial begin
    tbl[0]  = mk(0,0,0,0,0,32'h0,  32'h0,  32'h0,               32'h0,  0,0);
    tbl[1]  = mk(0,1,1,1,1,32'h40, 32'h0,  32'h0,               32'h0,  0,0);
    tbl[2]  = mk(1,0,0,0,0,32'h0,  32'h4,  32'h0043_0820,       32'h4,  1,0);
    tbl[3]  = mk(1,0,0,0,0,32'h0,  32'h8,  32'h8C22_0004,       32'h8,  1,0);
    tbl[4]  = mk(1,1,1,0,0,32'h0,  32'h8,  32'h8C22_0004,       32'h8,  1,0);
    tbl[5]  = mk(1,1,1,0,0,32'h0,  32'h8,  32'h8C22_0004,       32'h8,  1,0);
    tbl[6]  = mk(1,0,0,0,0,32'h0,  32'hC,  imem_word(32'h8),    32'hC,  1,0);
    tbl[7]  = mk(1,0,0,1,1,32'h40, 32'h40, 32'h0,               32'h0,  0,0);
    tbl[8]  = mk(1,0,0,0,0,32'h0,  32'h44, imem_word(32'h40),   32'h44, 1,0);
    tbl[9]  = mk(1,0,0,0,1,32'h10, 32'h10, imem_word(32'h44),   32'h48, 1,0);
    tbl[10] = mk(1,0,0,0,1,32'h42, 32'h14, imem_word(32'h10),   32'h14, 1,1);
    tbl[11] = mk(1,0,0,0,0,32'h0,  32'h18, imem_word(32'h14),   32'h18, 1,1);
    tbl[12] = mk(1,0,0,0,0,32'h0,  32'h1C, imem_word(32'h18),   32'h1C, 1,1);
    tbl[13] = mk(1,0,0,0,0,32'h0,  32'h20, imem_word(32'h1C),   32'h20, 1,1);
    tbl[14] = mk(1,0,0,0,0,32'h0,  32'h24, imem_word(32'h20),   32'h24, 1,1);
    tbl[15] = mk(1,0,0,0,0,32'h0,  32'h28, imem_word(32'h24),   32'h28, 1,1);
    tbl[16] = mk(1,0,1,0,0,32'h0,  32'h2C, imem_word(32'h24),   32'h28, 1,1);
    tbl[17] = mk(1,1,0,0,0,32'h0,  32'h2C, imem_word(32'h2C),   32'h30, 1,1);
    tbl[18] = mk(1,0,1,1,0,32'h0,  32'h30, 32'h0,               32'h0,  0,1);
    tbl[19] = mk(0,0,1,1,1,32'h80, 32'h0,  32'h0,               32'h0,  0,0);
    tbl[20] = mk(1,0,0,0,0,32'h0,  32'h4,  32'h0043_0820,       32'h4,  1,0);

    drive(0,0,0,0,0,32'h0);
    w_rst_n         = 1'b0;
    w_if.stallF     = 1'b0;
    w_if.stallD     = 1'b0;
    w_if.flushD     = 1'b0;
    w_if.pcSrcD     = 1'b0;
    w_if.pcBranchD  = 32'h0;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].rst_n, tbl[i].stallF, tbl[i].stallD, tbl[i].flushD, tbl[i].pcSrcD, tbl[i].br);
      @(posedge clk); #1;
      check_all(i, tbl[i].e_pc, tbl[i].e_instr, tbl[i].e_pp4, tbl[i].e_valid, tbl[i].e_aerr);
    end

    // wrap instance: held in reset so far, first edge after release wraps PC+4
    chk("wrap_rst_pc", 0, w_if.imemAddr, 32'hFFFF_FFFC);
    w_rst_n = 1'b1;
    @(posedge clk); #1;
    chk("wrap_pcPlus4D", 1, w_if.pcPlus4D, 32'h0);
    chk("wrap_pc",       1, w_if.imemAddr, 32'h0);
    chk("wrap_instrD",   1, w_if.instrD,   imem_word(32'hFFFF_FFFC));
    chk("wrap_alignErr", 1, {31'b0, w_if.alignErr}, 32'h0);
    @(posedge clk); #1;
    chk("wrap_pcPlus4D", 2, w_if.pcPlus4D, 32'h4);

    // randomized run against the reference model
    m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_aerr = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic        r, sf, sd, fl, ps;
      logic [31:0] br;
      logic [31:0] fetched, seq;
      r  = (c == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
      sf = ($urandom_range(0, 3) == 0);
      sd = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 5) == 0);
      ps = ($urandom_range(0, 4) == 0);
      br = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) br[1:0] = 2'b00;
      if (ps && br[1:0] != 2'b00) sf = 1'b0;
      drive(r, sf, sd, fl, ps, br);

      fetched = imem_word(m_pc);
      seq     = m_pc + 32'd4;
      if (!r) begin
        m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_aerr = 1'b0;
      end else begin
        if (fl) begin
          m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
        end else if (!sd) begin
          m_instr = fetched; m_pp4 = seq; m_valid = 1'b1;
        end
        if (!sf) begin
          if (ps && br[1:0] == 2'b00) m_pc = br;
          else begin
            m_pc = seq;
            if (ps) m_aerr = 1'b1;
          end
        end
      end

      @(posedge clk); #1;
      check_all(100 + c, m_pc, m_instr, m_pp4, m_valid, m_aerr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
